// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store sequencer: FSM states, access sizes,
// latched bus payload and byte-enable generation.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } lsu_state_e;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = DATA_W / 8;

    typedef struct packed {
        logic              we;
        logic [BE_W-1:0]   be;
        logic [DATA_W-1:0] wdata;
    } lsu_bus_t;

    // Byte lanes touched by an access of the given size at the given word offset.
    function automatic logic [BE_W-1:0] be_gen(input logic [1:0] size, input logic [1:0] off);
        logic [BE_W-1:0] be;
        case (size)
            SZ_B:    be = 4'b0001 << off;
            SZ_H:    be = 4'b0011 << off;
            SZ_W:    be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational data path of the sequencer: byte enables, legality check,
// store lane replication and load shift/extension.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]        size,
    input  logic [1:0]        off,
    input  logic [DATA_W-1:0] wdata,
    output logic [BE_W-1:0]   be,
    output logic              illegal,
    output logic [DATA_W-1:0] wdata_lane,
    input  logic [2:0]        ld_funct3,
    input  logic [1:0]        ld_off,
    input  logic [DATA_W-1:0] rdata,
    output logic [DATA_W-1:0] ld_data
);

    logic [DATA_W-1:0] shifted;
    logic              sext;

    // Request side: enables and illegal size / misalignment.
    always_comb begin
        be = be_gen(size, off);
        case (size)
            SZ_B:    illegal = 1'b0;
            SZ_H:    illegal = off[0];
            SZ_W:    illegal = |off;
            default: illegal = 1'b1;
        endcase
    end

    always_comb begin
        case (size)
            SZ_B:    wdata_lane = {4{wdata[7:0]}};
            SZ_H:    wdata_lane = {2{wdata[15:0]}};
            default: wdata_lane = wdata;
        endcase
    end

    // Response side: bring the addressed lane down to bit 0, then extend.
    always_comb begin
        shifted = rdata >> {ld_off, 3'b000};
        sext    = ~ld_funct3[2];
        case (ld_funct3[1:0])
            SZ_B:    ld_data = {{24{sext & shifted[7]}}, shifted[7:0]};
            SZ_H:    ld_data = {{16{sext & shifted[15]}}, shifted[15:0]};
            default: ld_data = shifted;
        endcase
    end

endmodule

// File: rtl/lsu_seq.sv
// Multi-cycle load/store sequencer between decoded memory controls and a req/ack bus.
// Optional REQ timeout enabled by defining LSU_TIMEOUT_EN.
module lsu_seq
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_mem_re,
    input  logic              i_mem_we,
    input  logic [2:0]        i_funct3,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [31:0]       i_wdata,
    output logic              o_stall,
    output logic              o_done,
    output logic              o_load_we,
    output logic [31:0]       o_rdata,
    output logic              o_fault,
    output logic              o_bus_req,
    output logic              o_bus_we,
    output logic [ADDR_W-1:0] o_bus_addr,
    output logic [3:0]        o_bus_be,
    output logic [31:0]       o_bus_wdata,
    input  logic              i_bus_ack,
    input  logic [31:0]       i_bus_rdata,
    input  logic              i_bus_err
);

    lsu_state_e        state_q, state_d;
    lsu_bus_t          bus_q;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        off_q;
    logic [2:0]        f3_q;
    logic              err_q;
    logic [31:0]       rdata_q;

    logic              req_c;
    logic              accept;
    logic              timeout_hit;
    logic              illegal;
    logic [BE_W-1:0]   be_c;
    logic [31:0]       wdata_c;
    logic [31:0]       ld_data;

    assign req_c = i_mem_re | i_mem_we;

    lsu_align u_align (
        .size       (i_funct3[1:0]),
        .off        (i_addr[1:0]),
        .wdata      (i_wdata),
        .be         (be_c),
        .illegal    (illegal),
        .wdata_lane (wdata_c),
        .ld_funct3  (f3_q),
        .ld_off     (off_q),
        .rdata      (i_bus_rdata),
        .ld_data    (ld_data)
    );

    // Next state and handshake outputs.
    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        o_stall   = 1'b0;
        o_done    = 1'b0;
        o_load_we = 1'b0;
        o_fault   = 1'b0;
        o_bus_req = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_c) begin
                    if (illegal) begin
                        o_done  = 1'b1;
                        o_fault = 1'b1;
                    end else begin
                        o_stall = 1'b1;
                        accept  = 1'b1;
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                o_bus_req = 1'b1;
                o_stall   = 1'b1;
                if (i_bus_ack || timeout_hit) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                o_done    = 1'b1;
                o_load_we = ~bus_q.we & ~err_q;
                o_fault   = err_q;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, request latches and response capture.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            bus_q   <= '0;
            addr_q  <= '0;
            off_q   <= '0;
            f3_q    <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                bus_q  <= '{we: i_mem_we, be: be_c, wdata: wdata_c};
                addr_q <= {i_addr[ADDR_W-1:2], 2'b00};
                off_q  <= i_addr[1:0];
                f3_q   <= i_funct3;
            end
            if (state_q == REQ && i_bus_ack) begin
                err_q <= i_bus_err;
                if (!bus_q.we) begin
                    rdata_q <= ld_data;
                end
            end else if (state_q == REQ && timeout_hit) begin
                err_q <= 1'b1;
            end
        end
    end

`ifdef LSU_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] to_cnt_q;

    // Counts REQ cycles without ack; an ack on the limit cycle takes priority.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            to_cnt_q <= '0;
        end else if (accept) begin
            to_cnt_q <= '0;
        end else if (state_q == REQ && !i_bus_ack) begin
            to_cnt_q <= to_cnt_q + CNT_W'(1);
        end
    end

    assign timeout_hit = (state_q == REQ) && !i_bus_ack &&
                         (to_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign timeout_hit    = 1'b0;
`endif

    assign o_bus_we    = bus_q.we;
    assign o_bus_be    = bus_q.be;
    assign o_bus_wdata = bus_q.wdata;
    assign o_bus_addr  = addr_q;
    assign o_rdata     = rdata_q;

endmodule

// File: doc/lsu_seq.md
Name: lsu_seq

Overview:
- Multi-cycle load/store sequencer between the core's decoded memory controls (mem_re/mem_we, funct3, ALU address, rs2 data) and a req/ack data-memory bus.
- Generates byte enables, lane-steers store data, and sign/zero-extends load data.
- Stalls PC/regfile until the access completes, and flags misaligned or errored accesses.
- One access outstanding at a time.

Parameters:
- ADDR_W, 32, width of i_addr and o_bus_addr.
- TIMEOUT_CYCLES, 255, REQ-state cycle limit; used only with LSU_TIMEOUT_EN.

Ports:
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  synchronous, active-low reset
- i_mem_re  in  1  load request from decode
- i_mem_we  in  1  store request from decode
- i_funct3  in  3  instr[14:12]: size [1:0], unsigned [2]
- i_addr  in  ADDR_W  effective address (ALU result)
- i_wdata  in  32  store data (rs2)
- o_stall  out  1  hold PC, IF and regfile writes
- o_done  out  1  one-cycle pulse: access finished
- o_load_we  out  1  pulse: write o_rdata to rd
- o_rdata  out  32  extended load result, valid when o_done=1
- o_fault  out  1  pulse: misaligned, illegal size or bus error
- o_bus_req  out  1  bus request
- o_bus_we  out  1  1 = write
- o_bus_addr  out  ADDR_W  word-aligned address ({i_addr[ADDR_W-1:2],2'b00})
- o_bus_be  out  4  byte enables
- o_bus_wdata  out  32  lane-replicated store data
- i_bus_ack  in  1  bus completes the request this cycle
- i_bus_rdata  in  32  read data, valid with i_bus_ack
- i_bus_err  in  1  bus error, valid with i_bus_ack

Behaviour:
- FSM states: IDLE, REQ, DONE.
- Reset (i_rst_n=0 at a rising edge):
  - state=IDLE; all outputs 0; internal registers cleared.
  - Reset mid-REQ drops o_bus_req on the next edge. A late ack is ignored.
- IDLE, no request:
  - o_stall=0; stays in IDLE.
- IDLE, (i_mem_re|i_mem_we) with a legal, aligned access:
  - o_stall=1 combinationally.
  - Latch op, be, steered wdata, addr and funct3.
  - Next state REQ.
- IDLE, illegal access:
  - Illegal means size=11, or half with addr[0]=1, or word with addr[1:0]!=0.
  - Pulse o_fault=1 and o_done=1 in that cycle; o_stall=0; no bus request.
  - Stays in IDLE.
- Both i_mem_re and i_mem_we high: treated as a store.
- REQ:
  - o_bus_req=1; o_stall=1; bus outputs held stable from the latched copies until ack.
  - On i_bus_ack: capture i_bus_rdata and i_bus_err; next state DONE.
- DONE:
  - o_done=1; o_stall=0. The core advances at the end of this cycle.
  - o_load_we=1 only if the op was a load and there was no error.
  - o_fault=i_bus_err as captured.
  - Next state IDLE.
- Latency: minimum 3 cycles per access (IDLE detect, REQ with same-cycle ack, DONE). Each extra ack-wait cycle adds 1.
- Byte enables:
  - byte: be = 4'b0001 << addr[1:0]
  - half: be = 4'b0011 << addr[1:0]
  - word: be = 4'b1111
- Store data lanes: byte replicated x4; half replicated x2; word passed through.
- Load data:
  - Shift captured rdata right by 8*addr[1:0], then take size bits.
  - Sign-extend when funct3[2]=0; zero-extend when funct3[2]=1.
- o_rdata holds its last value between accesses.
- i_bus_ack outside REQ is ignored.

Optional Feature:
- Macro: LSU_TIMEOUT_EN.
- Defined:
  - An 8+ bit counter (width $clog2(TIMEOUT_CYCLES+1)) clears on entry to REQ and increments each REQ cycle without ack.
  - When it reaches TIMEOUT_CYCLES: deassert o_bus_req, go to DONE with o_fault=1 and o_load_we=0.
  - An ack in the same cycle as the limit wins over the timeout.
- Undefined: no counter; REQ waits for ack indefinitely.

Decomposition:
- lsu_pkg holds:
  - state enum {IDLE, REQ, DONE}
  - funct3 size constants (SZ_B=2'b00, SZ_H=2'b01, SZ_W=2'b10)
  - the be-generation function
- Sub-module lsu_align (combinational) holds:
  - byte-enable generation and misalignment check
  - store lane replication
  - load shift and extension
- lsu_seq holds the FSM, latches and optional timeout.

Test Plan:
1. SW addr=0x100, wdata=0xDEADBEEF, ack after 2 wait cycles -> be=1111, addr=0x100, wdata=0xDEADBEEF; req held 3 cycles; o_done 1 cycle after ack; o_stall high 4 cycles total; o_load_we=0.
2. LB addr=0x103, rdata=0x80xxxxxx, ack immediate -> be=1000; o_rdata=0xFFFFFF80; o_load_we=1; access takes 3 cycles. Repeat as LBU -> 0x00000080.
3. SH addr=0x102, wdata=0x0000ABCD -> be=1100, o_bus_wdata=0xABCDABCD. LH at the same address with rdata=0x7FFF0000 -> 0x00007FFF.
4. LW addr=0x101 -> o_fault=1 and o_done=1 same cycle; o_bus_req never asserted; o_stall=0. Repeat with funct3=011 -> same fault.
5. LW addr=0x200, ack with i_bus_err=1 -> o_fault=1, o_load_we=0 in DONE.
6. Reset asserted in the 2nd REQ cycle -> o_bus_req=0 next edge; state IDLE. An ack next cycle produces no o_done.
   - With LSU_TIMEOUT_EN and TIMEOUT_CYCLES=4, no ack -> req drops after 4 REQ cycles; o_fault=1.
